audio_alarm_scheduler: RTL and testbench

//  Shares the single buzzer between four alarm sources in the temperature alarm system.

---
 rtl/audio_alarm_pkg.sv | 70 +++++++
 rtl/audio_tone_gen.sv | 41 ++++
 rtl/audio_alarm_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_audio_alarm_scheduler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/audio_alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_alarm_pkg                                              |
// | Description : Shared constants for the alarm buzzer scheduler: note        |
// |               frequencies, source indices, FSM encoding and the per-source |
// |               beep pattern table (tone, ON ticks, OFF ticks).              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package audio_alarm_pkg;

  // Note frequencies in Hz: low, middle and high octaves.
  localparam int L1 = 262;
  localparam int L2 = 294;
  localparam int L3 = 330;
  localparam int L4 = 349;
  localparam int L5 = 392;
  localparam int L6 = 440;
  localparam int L7 = 494;
  localparam int M1 = 523;
  localparam int M2 = 587;
  localparam int M3 = 659;
  localparam int M4 = 698;
  localparam int M5 = 784;
  localparam int M6 = 880;
  localparam int M7 = 988;
  localparam int H1 = 1046;
  localparam int H2 = 1175;
  localparam int H3 = 1318;
  localparam int H4 = 1397;
  localparam int H5 = 1568;
  localparam int H6 = 1760;
  localparam int H7 = 1976;

  // Source indices; a higher index has higher priority.
  localparam int SRC_CLICK = 0;
  localparam int SRC_UNDER = 1;
  localparam int SRC_OVER  = 2;
  localparam int SRC_FAULT = 3;
  localparam int NUM_SRC   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Pattern table, indexed by source.
  localparam int TONE_HZ   [NUM_SRC] = '{M1, M5, H1, H5};
  localparam int ON_TICKS  [NUM_SRC] = '{5, 50, 25, 10};
  localparam int OFF_TICKS [NUM_SRC] = '{0, 50, 25, 10};

  // Clock cycles per tone half-period, never below one.
  function automatic int half_cycles(input int clk_hz, input int tone_hz);
    int h;
    h = clk_hz / (2 * tone_hz);
    return (h < 1) ? 1 : h;
  endfunction

  // Index of the highest set bit; 0 when nothing is set.
  function automatic logic [1:0] top_index(input logic [3:0] elig);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_tone_gen                                               |
// | Description : Square-wave generator. Counts Half cycles, then toggles the  |
// |               output. Clear zeroes both counter and output.                |
// | Ports       : Clk, Reset (sync, active-low), Clear, Run, Half -> Audio     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module audio_tone_gen #(
  parameter int HALF_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Run,
  input  logic [HALF_W-1:0] Half,
  output logic              Audio
);

  logic [HALF_W-1:0] r_cnt;
  logic              r_audio;

  // First toggle lands exactly Half cycles after the clearing edge.
  always_ff @(posedge Clk) begin
    if (!Reset || Clear) begin
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else if (Run) begin
      if (r_cnt == Half - HALF_W'(1)) begin
        r_cnt   <= '0;
        r_audio <= ~r_audio;
      end else begin
        r_cnt <= r_cnt + HALF_W'(1);
      end
    end
  end

  assign Audio = r_audio;

endmodule
`default_nettype wire

// File: rtl/audio_alarm_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_alarm_scheduler                                        |
// | Description : Shares one buzzer between four alarm sources with fixed     |
// |               priority and preemption; plays each source's beep pattern.   |
// | Ports       : Clk, Reset (sync, active-low), Req[3:0], Mute               |
// |               -> Grant[3:0] (one-hot owner), Busy, Audio, Audio_enable     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module audio_alarm_scheduler
  import audio_alarm_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       Mute,
  output logic [3:0] Grant,
  output logic       Busy,
  output logic       Audio,
  output logic       Audio_enable
);

  localparam int HALF_0   = half_cycles(CLK_HZ, TONE_HZ[SRC_CLICK]);
  localparam int HALF_1   = half_cycles(CLK_HZ, TONE_HZ[SRC_UNDER]);
  localparam int HALF_2   = half_cycles(CLK_HZ, TONE_HZ[SRC_OVER]);
  localparam int HALF_3   = half_cycles(CLK_HZ, TONE_HZ[SRC_FAULT]);
  localparam int HALF_M01 = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
  localparam int HALF_M23 = (HALF_2 > HALF_3) ? HALF_2 : HALF_3;
  localparam int HALF_MAX = (HALF_M01 > HALF_M23) ? HALF_M01 : HALF_M23;
  localparam int HALF_W   = $clog2(HALF_MAX + 1);
  localparam int TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t            r_state;
  logic [1:0]        r_src;
  logic [3:0]        r_grant;
  logic              r_busy;
  logic [TICK_W-1:0] r_tick;
  logic [5:0]        r_phase;
  logic              r_click_pend;

  logic [3:0]        w_elig;
  logic              w_any;
  logic [1:0]        w_win;
  logic              w_preempt;
  logic [5:0]        w_on_len;
  logic [5:0]        w_off_len;
  logic [5:0]        w_limit;
  logic              w_tick_last;
  logic              w_phase_last;
  logic [HALF_W-1:0] w_half;
  logic              w_start_on;
  logic              w_to_off;
  logic              w_to_idle;
  logic              w_click_start;
  logic              w_tone_clear;

  // A click is eligible in the very cycle of its pulse as well as while latched.
  assign w_elig    = {Req[3:1], r_click_pend | Req[0]};
  assign w_any     = |w_elig;
  assign w_win     = top_index(w_elig);
  assign w_preempt = (r_state != ST_IDLE) && w_any && (w_win > r_src);

  always_comb begin
    w_on_len  = 6'd0;
    w_off_len = 6'd0;
    w_half    = '0;
    case (r_src)
      2'd0: begin
        w_on_len  = 6'(ON_TICKS[SRC_CLICK]);
        w_off_len = 6'(OFF_TICKS[SRC_CLICK]);
        w_half    = HALF_W'(HALF_0);
      end
      2'd1: begin
        w_on_len  = 6'(ON_TICKS[SRC_UNDER]);
        w_off_len = 6'(OFF_TICKS[SRC_UNDER]);
        w_half    = HALF_W'(HALF_1);
      end
      2'd2: begin
        w_on_len  = 6'(ON_TICKS[SRC_OVER]);
        w_off_len = 6'(OFF_TICKS[SRC_OVER]);
        w_half    = HALF_W'(HALF_2);
      end
      default: begin
        w_on_len  = 6'(ON_TICKS[SRC_FAULT]);
        w_off_len = 6'(OFF_TICKS[SRC_FAULT]);
        w_half    = HALF_W'(HALF_3);
      end
    endcase
  end

  assign w_limit      = (r_state == ST_ON) ? w_on_len : w_off_len;
  assign w_tick_last  = (r_tick == TICK_W'(TICK_CYCLES - 1));
  assign w_phase_last = w_tick_last && (r_phase == w_limit - 6'd1);

  // Transition decode; the registered FSM below applies it.
  always_comb begin
    w_start_on = 1'b0;
    w_to_off   = 1'b0;
    w_to_idle  = 1'b0;
    case (r_state)
      ST_IDLE: w_start_on = w_any;
      ST_ON: begin
        if (w_preempt) begin
          w_start_on = 1'b1;
        end else if (w_phase_last) begin
          if (w_off_len != 6'd0) w_to_off   = 1'b1;
          else if (w_any)        w_start_on = 1'b1;
          else                   w_to_idle  = 1'b1;
        end
      end
      ST_OFF: begin
        if (w_preempt) begin
          w_start_on = 1'b1;
        end else if (w_phase_last) begin
          if (w_any) w_start_on = 1'b1;
          else       w_to_idle  = 1'b1;
        end
      end
      default: w_to_idle = 1'b1;
    endcase
  end

  assign w_click_start = w_start_on && (w_win == 2'(SRC_CLICK));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_src        <= 2'd0;
      r_grant      <= 4'd0;
      r_busy       <= 1'b0;
      r_tick       <= '0;
      r_phase      <= 6'd0;
      r_click_pend <= 1'b0;
    end else if (Mute) begin
      r_state      <= ST_IDLE;
      r_src        <= 2'd0;
      r_grant      <= 4'd0;
      r_busy       <= 1'b0;
      r_tick       <= '0;
      r_phase      <= 6'd0;
      r_click_pend <= 1'b0;
    end else begin
      // Starting a click consumes the latch; a pulse during playback re-arms it.
      r_click_pend <= w_click_start ? 1'b0 : (r_click_pend | Req[0]);
      if (w_start_on) begin
        r_state <= ST_ON;
        r_src   <= w_win;
        r_grant <= 4'b0001 << w_win;
        r_busy  <= 1'b1;
        r_tick  <= '0;
        r_phase <= 6'd0;
      end else if (w_to_off) begin
        r_state <= ST_OFF;
        r_tick  <= '0;
        r_phase <= 6'd0;
      end else if (w_to_idle) begin
        r_state <= ST_IDLE;
        r_src   <= 2'd0;
        r_grant <= 4'd0;
        r_busy  <= 1'b0;
        r_tick  <= '0;
        r_phase <= 6'd0;
      end else if (r_state != ST_IDLE) begin
        if (w_tick_last) begin
          r_tick  <= '0;
          r_phase <= r_phase + 6'd1;
        end else begin
          r_tick <= r_tick + TICK_W'(1);
        end
      end
    end
  end

  // Tone restarts from zero on every phase entry and is held silent outside ON.
  assign w_tone_clear = (r_state != ST_ON) || w_start_on || w_to_off || w_to_idle || Mute;

  audio_tone_gen #(
    .HALF_W (HALF_W)
  ) u_tone (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (w_tone_clear),
    .Run   (r_state == ST_ON),
    .Half  (w_half),
    .Audio (Audio)
  );

  assign Grant        = r_grant;
  assign Busy         = r_busy;
  assign Audio_enable = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_audio_alarm_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_audio_alarm_scheduler                                     |
// | Description : Directed self-checking bench for audio_alarm_scheduler with  |
// |               CLK_HZ=20000, TICK_CYCLES=4 (HALF 19/12/9/6 for src0..3).    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_audio_alarm_scheduler;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b0;
  logic       Mute  = 1'b0;
  logic [3:0] Req   = 4'd0;
  logic [3:0] Grant;
  logic       Busy;
  logic       Audio;
  logic       Audio_enable;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  audio_alarm_scheduler #(
    .CLK_HZ      (20_000),
    .TICK_CYCLES (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req          (Req),
    .Mute         (Mute),
    .Grant        (Grant),
    .Busy         (Busy),
    .Audio        (Audio),
    .Audio_enable (Audio_enable)
  );

  // Checks n consecutive cycles at the falling edge. g is the expected owner
  // (0 = idle); when on=1 the tone is expected to toggle every half cycles,
  // k0 being the cycle index within the ON phase of the first sample.
  task automatic expect_seq(input string tag, input int n, input logic [3:0] g,
                            input logic on, input int half, input int k0);
    logic [6:0] obs;
    logic [6:0] exp;
    logic       b;
    logic       a;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      b   = (g != 4'd0);
      a   = (on && half > 0) ? 1'(((k + k0) / half) % 2) : 1'b0;
      exp = {g, b, b, a};
      obs = {Grant, Busy, Audio_enable, Audio};
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s[%0d] observed={grant,busy,en,audio}=%b expected=%b",
               tag, k + k0, obs, exp);
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Req   = 4'd0;
    Mute  = 1'b0;
    expect_seq("reset_clear", 1, 4'd0, 1'b0, 0, 0);
    Reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset, then src2 held: 100 ON (half 9), 100 OFF, ON repeats.
    expect_seq("reset", 3, 4'd0, 1'b0, 0, 0);
    Reset = 1'b1;
    Req   = 4'b0100;
    expect_seq("t1_on",     100, 4'b0100, 1'b1, 9, 0);
    expect_seq("t1_off",    100, 4'b0100, 1'b0, 0, 0);
    expect_seq("t1_on_rep",  10, 4'b0100, 1'b1, 9, 0);
    do_reset();

    // 2. src1 playing, src3 preempts, src3 completes after release, src1 resumes.
    Req = 4'b0010;
    expect_seq("t2_src1", 30, 4'b0010, 1'b1, 12, 0);
    Req = 4'b1010;
    expect_seq("t2_src3_on", 5, 4'b1000, 1'b1, 6, 0);
    Req = 4'b0010;
    expect_seq("t2_src3_on",    35, 4'b1000, 1'b1, 6, 5);
    expect_seq("t2_src3_off",   40, 4'b1000, 1'b0, 0, 0);
    expect_seq("t2_src1_fresh", 20, 4'b0010, 1'b1, 12, 0);
    do_reset();

    // 3. Click pulsed during src2 ON, src2 dropped: src2 completes, then click, then idle.
    Req = 4'b0100;
    expect_seq("t3_src2_on", 20, 4'b0100, 1'b1, 9, 0);
    Req = 4'b0101;
    expect_seq("t3_src2_on", 1, 4'b0100, 1'b1, 9, 20);
    Req = 4'b0000;
    expect_seq("t3_src2_on",  79, 4'b0100, 1'b1, 9, 21);
    expect_seq("t3_src2_off", 100, 4'b0100, 1'b0, 0, 0);
    expect_seq("t3_click",    20, 4'b0001, 1'b1, 19, 0);
    expect_seq("t3_idle",      3, 4'b0000, 1'b0, 0, 0);

    // 4. Mute mid-ON silences next cycle; unmute restarts ON.
    Req = 4'b0010;
    expect_seq("t4_on", 15, 4'b0010, 1'b1, 12, 0);
    Mute = 1'b1;
    expect_seq("t4_muted", 3, 4'b0000, 1'b0, 0, 0);
    Mute = 1'b0;
    expect_seq("t4_resume", 20, 4'b0010, 1'b1, 12, 0);
    do_reset();

    // 5. src1 held only 10 cycles: full 200 ON + 200 OFF, then idle.
    Req = 4'b0010;
    expect_seq("t5_on", 10, 4'b0010, 1'b1, 12, 0);
    Req = 4'b0000;
    expect_seq("t5_on",  190, 4'b0010, 1'b1, 12, 10);
    expect_seq("t5_off", 200, 4'b0010, 1'b0, 0, 0);
    expect_seq("t5_idle",  3, 4'b0000, 1'b0, 0, 0);

    // 6. Reset pulse mid-ON of src3: no asynchronous effect, zero after the edge, then restart.
    Req = 4'b1000;
    expect_seq("t6_on", 20, 4'b1000, 1'b1, 6, 0);
    Reset = 1'b0;
    #1;
    vectors++;
    assert ({Grant, Busy, Audio_enable} === 6'b1000_11) else begin
      miscompares++;
      $error("FAIL t6_no_async observed={grant,busy,en}=%b expected=100011",
             {Grant, Busy, Audio_enable});
    end
    expect_seq("t6_reset", 1, 4'd0, 1'b0, 0, 0);
    Reset = 1'b1;
    expect_seq("t6_restart", 12, 4'b1000, 1'b1, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
